// File: rtl/idp_enc_scheduler.sv
// rtl/idp_enc_scheduler.sv - round-robin scheduler sharing one IDP encoder, with a credit-protected tagged output FIFO
`ifndef IBLEN16
`define IBLEN16 12
`endif

module idp_enc_scheduler #(
  parameter int N_REQ = 4,
  parameter int DW = `IBLEN16,
  parameter int CW = 16,
  parameter int FIFO_DEPTH = 4,
  parameter longint unsigned MAX_WORD = (64'd1 << DW) - 64'd1,
  localparam int TW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic [N_REQ-1:0]    req_err,
  output logic [DW-1:0]       enc_datain,
  input  logic [CW-1:0]       enc_codeout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CW-1:0]       out_code,
  output logic [TW-1:0]       out_tag,
  output logic                busy
);

  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW  = $clog2(FIFO_DEPTH + 1);
  localparam int CRW = $clog2(FIFO_DEPTH + 3) + 1;

  logic [TW-1:0] rr;
  logic          s1v;
  logic [TW-1:0] s1_tag;
  logic          s2v;
  logic [TW-1:0] s2_tag;
  logic [NW-1:0] fifo_count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] mem_code [FIFO_DEPTH];
  logic [TW-1:0] mem_tag  [FIFO_DEPTH];

  logic           pop;
  logic [CRW-1:0] credit;
  logic           credit_ok;
  logic           found;
  logic [TW-1:0]  cand;
  logic [TW-1:0]  gnt_idx;
  logic [TW-1:0]  next_rr;
  logic [DW-1:0]  gnt_word;
  logic           word_bad;
  logic           grant;
  logic           load;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Every word in S1, S2 or the FIFO owns a FIFO slot, so a push can never find it full.
  always_comb begin
    pop       = out_valid & out_ready;
    credit    = CRW'(s1v) + CRW'(s2v) + CRW'(fifo_count);
    credit_ok = (credit - CRW'(pop)) < CRW'(FIFO_DEPTH);
  end

  always_comb begin
    found   = 1'b0;
    cand    = '0;
    gnt_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = TW'((int'(rr) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    gnt_word  = req_data[int'(gnt_idx)*DW +: DW];
    word_bad  = 64'(gnt_word) > MAX_WORD;
    grant     = found & credit_ok & ~reset;
    load      = grant & ~word_bad;
    next_rr   = (gnt_idx == TW'(N_REQ - 1)) ? '0 : gnt_idx + TW'(1);
    req_ready = grant ? (N_REQ'(1) << gnt_idx) : '0;
    req_err   = (grant && word_bad) ? (N_REQ'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr         <= '0;
      s1v        <= 1'b0;
      s1_tag     <= '0;
      enc_datain <= '0;
      s2v        <= 1'b0;
      s2_tag     <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      if (grant) rr <= next_rr;
      s1v <= load;
      if (load) begin
        enc_datain <= gnt_word;
        s1_tag     <= gnt_idx;
      end
      s2v    <= s1v;
      s2_tag <= s1_tag;
      if (s2v) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({s2v, pop})
        2'b10:   fifo_count <= fifo_count + NW'(1);
        2'b01:   fifo_count <= fifo_count - NW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // The encoder's registered code is valid exactly when the S2 shadow is valid.
  always_ff @(posedge clock) begin
    if (s2v) begin
      mem_code[wr_ptr] <= enc_codeout;
      mem_tag[wr_ptr]  <= s2_tag;
    end
  end

  assign out_valid = (fifo_count != '0);
  assign out_code  = out_valid ? mem_code[rd_ptr] : '0;
  assign out_tag   = out_valid ? mem_tag[rd_ptr] : '0;
  assign busy      = s1v | s2v | out_valid;

endmodule

// File: doc/idp_enc_scheduler.md
# idp_enc_scheduler

Round-robin scheduler that shares one 16-wire IDP/FNS encoder (`IDP_encoder_16`) among `N_REQ` requesters. It arbitrates valid/ready requests and drives the encoder's `datain` from a register. It tracks each word through the encoder's one-cycle registered output and returns the 16-bit codeword, tagged with the requester index, through a credit-protected output FIFO with valid/ready backpressure. It sits between the link-layer word sources and the TSV/bus driver stage.

## Interface
- `N_REQ`, 4 — number of requesters, 2..8.
- `DW`, `` `IBLEN16 `` — data word width (encoder input width).
- `CW`, 16 — codeword width.
- `FIFO_DEPTH`, 4 — output FIFO entries; minimum 3 for full throughput.
- `MAX_WORD`, 2^DW−1 — largest legal input word; larger words are rejected.
- `clock` in 1 — single clock; all state updates on the rising edge.
- `reset` in 1 — asynchronous, active-high; clears all state.
- `req_valid` in N_REQ — per-requester request valid.
- `req_data` in N_REQ*DW — requester i occupies bits [i*DW +: DW].
- `req_ready` out N_REQ — one-hot grant; a word transfers when `req_valid[i] & req_ready[i]` is high at the edge.
- `req_err` out N_REQ — one-hot; high in the grant cycle when the granted word exceeds `MAX_WORD`.
- `enc_datain` out DW — registered; connects to encoder `datain`.
- `enc_codeout` in CW — encoder `codeout`, valid one edge after `enc_datain` is loaded.
- `out_valid` out 1 — FIFO head valid.
- `out_ready` in 1 — downstream accepts the head.
- `out_code` out CW — head codeword.
- `out_tag` out clog2(N_REQ) — head requester index.
- `busy` out 1 — any word is in stage 1, stage 2 or the FIFO.

## Operation
- **Pipeline**
  - S1: `enc_datain` plus tag/valid, loaded on accept.
  - S2: encoder register, with a shadow tag/valid in the scheduler.
  - FIFO: push of `{tag, enc_codeout}` when S2 is valid.
- **Credits**
  - C = S1v + S2v + fifo_count.
  - Grant is permitted only if C − pop < `FIFO_DEPTH`, where pop = `out_valid & out_ready` this cycle.
  - This guarantees a FIFO push never meets a full FIFO.
- **Arbitration**
  - Round-robin pointer `rr`, reset to 0.
  - The first requester with `req_valid` set, searching from `rr` upward with wrap, is granted when credits permit.
  - `req_ready` is combinational from `req_valid`, `rr` and credits. At most one bit is set.
  - After any transfer, `rr` ← granted index + 1 mod N_REQ.
  - `rr` is unchanged when nothing transfers.
- **Range check**
  - If the granted word > `MAX_WORD`, `req_ready` and `req_err` assert for that requester in the same cycle, and the word is consumed.
  - A rejected word does not load S1.
  - `rr` advances as for a normal transfer.
- **Encoder register**
  - `enc_datain` holds its last value when S1 is not loaded. Only S1v governs tracking.
- **FIFO**
  - Show-ahead; `out_code`/`out_tag` present the head.
  - Simultaneous push and pop leaves the count unchanged.
  - Order is strict accept order across all requesters.
- **Reset**
  - Takes effect at any time, including mid-burst.
  - Clears S1v, S2v, the FIFO count and `rr`, and discards in-flight words.
  - Outputs during and after reset: `enc_datain`=0, `req_ready`=0, `req_err`=0, `out_valid`=0, `out_code`=0, `out_tag`=0, `busy`=0.
  - After deassertion, the first grant is possible in the first cycle.

## Timing
- Accept at edge E0 loads S1. The encoder captures the code at E1. The FIFO push happens at E2.
- `out_valid` rises after E2 when the FIFO was empty. Latency is 2 edges from accept to the codeword at the head.
- Throughput is 1 word/clock while `out_ready`=1 and `FIFO_DEPTH` ≥ 3.
- With `out_ready`=0, at most `FIFO_DEPTH` words are accepted. `req_ready` then stays 0 until a pop.
- A pop in cycle t allows a grant in the same cycle t.
- `busy` is registered-state derived, with no combinational input paths.

## Test plan
- **Single word:** requester 2 sends `req_data`=1 → `req_ready[2]` high one cycle. `out_valid` high 2 edges later with `out_code`=16'h0001, `out_tag`=2, then `busy`→0.
- **Round-robin order:** all 4 requesters valid continuously from reset with data 0,1,0,1; `out_ready`=1 → accepts in tag order 0,1,2,3,0,… at 1 word/clock. Codes alternate 16'h0000/16'h0001.
- **Backpressure:** `out_ready`=0 for 10 cycles with requester 0 streaming → exactly 4 words accepted and `req_ready` held 0 after that. Raising `out_ready` delivers all words in order with no loss or duplication.
- **Out-of-range:** `MAX_WORD`=100; requester 1 sends 101 → `req_err[1]`=1 and `req_ready[1]`=1 for 1 cycle, no output word, `rr` advances to 2. A following word 100 is encoded normally.
- **Reset mid-burst:** assert `reset` with S1, S2 and 2 FIFO entries occupied → `out_valid`, `busy`, `req_ready`, `enc_datain` immediately 0. After release, a new word returns with 2-edge latency and no stale words emerge.
- **Pop/grant same cycle:** FIFO full with `out_ready` pulsed for 1 cycle → exactly one new grant in that cycle. FIFO count never exceeds `FIFO_DEPTH`.
